// File: rtl/ram_wb_pkg.sv
// Shared codes for the Wishbone B3 RAM front-end: cycle/burst types, FSM states, range check.
// Purely declarative; no timing or backpressure of its own.
package ram_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RMW   = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  function automatic logic word_in_range(input logic [31:0] widx, input logic [31:0] size);
    return widx < size;
  endfunction

endpackage

// File: rtl/ram_wb_b3_ctrl_if.sv
// Wishbone B3 slave bus plus the single-port RAM strobes it drives.
// Wires only; ack/err from the controller are the sole flow control.
interface ram_wb_b3_ctrl_if #(parameter int adr_width = 18);

  logic [31:0]          wb_adr_i;
  logic [31:0]          wb_dat_i;
  logic [3:0]           wb_sel_i;
  logic                 wb_we_i;
  logic                 wb_cyc_i;
  logic                 wb_stb_i;
  logic [2:0]           wb_cti_i;
  logic [1:0]           wb_bte_i;
  logic [31:0]          wb_dat_o;
  logic                 wb_ack_o;
  logic                 wb_err_o;

  logic [adr_width-1:0] ram_adr_o;
  logic [31:0]          ram_dat_o;
  logic                 ram_we_o;
  logic [31:0]          ram_dat_i;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output ram_adr_o, ram_dat_o, ram_we_o,
    input  ram_dat_i
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport ram (
    input  ram_adr_o, ram_dat_o, ram_we_o,
    output ram_dat_i
  );

endinterface

// File: rtl/ram_wb_burst_adr.sv
// Next burst word address for linear and wrap-4/8/16 bursts; combinational, zero latency.
// carry flags a linear increment that rolled past the top of the address space.
module ram_wb_burst_adr
  import ram_wb_pkg::*;
#(
  parameter int adr_width = 18
) (
  input  logic [adr_width-1:0] adr,
  input  bte_e                 bte,
  output logic [adr_width-1:0] nxt,
  output logic                 carry
);

  localparam logic [adr_width:0] ONE = 1;

  logic [adr_width:0] lin;

  always_comb begin
    lin   = {1'b0, adr} + ONE;
    nxt   = lin[adr_width-1:0];
    carry = 1'b0;
    case (bte)
      BTE_LINEAR: begin
        nxt   = lin[adr_width-1:0];
        carry = lin[adr_width];
      end
      BTE_WRAP4:  nxt = {adr[adr_width-1:2], adr[1:0] + 2'd1};
      BTE_WRAP8:  nxt = {adr[adr_width-1:3], adr[2:0] + 3'd1};
      default:    nxt = {adr[adr_width-1:4], adr[3:0] + 4'd1};
    endcase
  end

endmodule

// File: rtl/ram_wb_b3_ctrl.sv
// Wishbone B3 slave to single-port RAM: classic/burst reads, full and RMW partial writes, range errors.
// Ack/err one cycle after request (two for partial writes); bursts stream one beat per cycle, no stalls.
module ram_wb_b3_ctrl
  import ram_wb_pkg::*;
#(
  parameter int adr_width = 18,
  parameter int mem_size  = 262144
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  ram_wb_b3_ctrl_if.slave  bus
);

  localparam logic [31:0] MEM_WORDS = 32'(mem_size);

  state_e               state;
  logic                 ack;
  logic                 err;
  logic [adr_width-1:0] badr;
  logic                 badr_ovf;

  logic [31:0]          req_widx;
  logic [adr_width-1:0] req_idx;
  logic                 req;
  logic                 req_ok;
  logic                 full_wr;
  logic                 burst_live;
  logic                 badr_ok;
  logic [adr_width-1:0] nxt_src;
  logic [adr_width-1:0] nxt_adr;
  logic                 nxt_carry;
  logic [31:0]          merged;
  logic [adr_width-1:0] ram_adr;
  logic [31:0]          ram_dat;
  logic                 ram_we;
  logic                 unused_ok;

  assign req_widx   = {2'b00, bus.wb_adr_i[31:2]};
  assign req_idx    = bus.wb_adr_i[adr_width+1:2];
  assign req        = bus.wb_cyc_i & bus.wb_stb_i & ~ack & ~err;
  assign req_ok     = word_in_range(req_widx, MEM_WORDS);
  assign full_wr    = (bus.wb_sel_i == 4'hF);
  assign burst_live = bus.wb_cyc_i & bus.wb_stb_i & ~bus.wb_we_i & (bus.wb_cti_i == CTI_INCR);
  // the sticky overflow catches a linear burst that stepped past 2^adr_width
  assign badr_ok    = ~badr_ovf & word_in_range(32'(badr), MEM_WORDS);
  assign nxt_src    = (state == ST_BURST) ? badr : req_idx;
  assign unused_ok  = &{1'b0, bus.wb_adr_i[1:0]};

  ram_wb_burst_adr #(.adr_width(adr_width)) u_burst_adr (
    .adr   (nxt_src),
    .bte   (bte_e'(bus.wb_bte_i)),
    .nxt   (nxt_adr),
    .carry (nxt_carry)
  );

  always_comb begin
    merged = bus.ram_dat_i;
    for (int b = 0; b < 4; b++) begin
      if (bus.wb_sel_i[b]) merged[8*b +: 8] = bus.wb_dat_i[8*b +: 8];
    end
  end

  // RAM strobes are combinational so the address lands in the request cycle
  always_comb begin
    ram_adr = req_idx;
    ram_dat = bus.wb_dat_i;
    ram_we  = 1'b0;
    case (state)
      ST_IDLE:  ram_we = req & req_ok & bus.wb_we_i & full_wr;
      ST_RMW: begin
        ram_we  = bus.wb_cyc_i & bus.wb_stb_i & bus.wb_we_i;
        ram_dat = merged;
      end
      ST_BURST: ram_adr = badr;
      default:  ram_we = 1'b0;
    endcase
    if (wb_rst_i) ram_we = 1'b0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      ack      <= 1'b0;
      err      <= 1'b0;
      badr     <= '0;
      badr_ovf <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (!req_ok) begin
              err <= 1'b1;
            end else if (bus.wb_we_i) begin
              if (full_wr) ack <= 1'b1;
              else         state <= ST_RMW;
            end else begin
              ack <= 1'b1;
              if (bus.wb_cti_i == CTI_INCR) begin
                state    <= ST_BURST;
                badr     <= nxt_adr;
                badr_ovf <= nxt_carry;
              end
            end
          end
        end
        ST_RMW: begin
          state <= ST_IDLE;
          ack   <= bus.wb_cyc_i & bus.wb_stb_i & bus.wb_we_i;
        end
        ST_BURST: begin
          state <= ST_IDLE;
          if (burst_live) begin
            if (!badr_ok) begin
              err <= 1'b1;
            end else begin
              ack      <= 1'b1;
              state    <= ST_BURST;
              badr     <= nxt_adr;
              badr_ovf <= badr_ovf | nxt_carry;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.wb_ack_o  = ack;
  assign bus.wb_err_o  = err;
  assign bus.wb_dat_o  = bus.ram_dat_i;
  assign bus.ram_adr_o = ram_adr;
  assign bus.ram_dat_o = ram_dat;
  assign bus.ram_we_o  = ram_we;

endmodule
